ring_hal_bridge: RTL and testbench
==================================

// Module: ring_hal_bridge
// PURPOSE
//  Ring-stop endpoint that turns ring request packets into HAL host-memory reads/writes and
//  returns acks/data to the requester as ring packets. Parametrised successor of the single-
//  outstanding mem_controller: configurable widths, queue depth, MMIO base and HAL timeout,
//  with queued requests, back-pressure onto the ring, and same-slot response injection.
// PARAMETERS
//  ADDR_W   36   ring address width
//  DATA_W   512  ring/HAL data width
//  ID_W     5    requester id width
//  DEPTH    4    request queue entries (power of 2, >=2)
//  MMIO_W   28   low HAL address bits taken from mmio_addr
//  TIMEOUT  1024 HAL cycles before err_timeout (0 = disabled)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous active-high reset
//  ring_type_i  in   3       packet type in current ring slot (000 empty,001 wr req,011 rd req)
//  ring_id_i    in   ID_W    slot requester id
//  ring_addr_i  in   ADDR_W  slot address
//  ring_data_i  in   DATA_W  slot data (write payload)
//  ring_ovr_o   out  1       overwrite current slot with ring_*_o this cycle
//  ring_type_o  out  3       replacement type (000 = clear slot, 101 wr ack, 110 rd resp)
//  ring_id_o    out  ID_W    replacement id
//  ring_addr_o  out  ADDR_W  replacement address (echo of request)
//  ring_data_o  out  DATA_W  replacement data (rd data; 0 for wr ack)
//  mmio_addr    in   MMIO_W  base bits appended below ring address
//  rd_go/wr_go  out  1       HAL read/write request, held until matching done
//  rd_addr      out  64      {zero-ext ring addr, mmio_addr}; wr_addr same format
//  wr_data      out  DATA_W  HAL write payload
//  rd_done      in   1       HAL read complete, rd_data valid this cycle
//  rd_data      in   DATA_W  HAL read data
//  empty        in   1       HAL read stall (rd_done will not assert while high)
//  wr_done      in   1       HAL write accepted
//  full         in   1       HAL write stall
//  q_level      out  $clog2(DEPTH)+1  queue occupancy
//  err_timeout  out  1       sticky: HAL op exceeded TIMEOUT cycles
// BEHAVIOUR
//  Reset: all outputs 0, queue empty, FSM IDLE, response buffer invalid, timer 0. Reset during
//   an HAL op drops it; rd_go/wr_go low the cycle after rst sampled; no ack is ever generated.
//  Ingress: slot type 001/011 and q_level<DEPTH -> push {type,id,addr,data}, consume slot
//   (ring_ovr_o=1). Queue full -> slot untouched, packet keeps circulating. Other types ignored.
//  FSM IDLE: queue non-empty and resp buffer invalid -> pop head; 011 -> RD_WAIT, 001 -> WR_WAIT.
//   go asserts cycle after pop; addr/data stable while go high. Push-to-go latency on empty
//   idle queue = 1 cycle.
//  RD_WAIT: rd_done -> capture rd_data into resp buffer (type 110), go low next cycle, -> RESP.
//  WR_WAIT: wr_done -> resp buffer type 101, data 0, -> RESP. empty/full only extend waits.
//  Timer counts each cycle in *_WAIT, clears on done; reaching TIMEOUT sets err_timeout (sticky
//   to reset); op keeps waiting (no abort).
//  RESP: inject when slot type 000, or when same slot is consumed by ingress this cycle (response
//   replaces request in one overwrite). Slot holds a response/foreign type or unconsumable
//   request -> wait. After inject -> IDLE; next pop same cycle is not allowed (1 bubble).
//  Simultaneous done + ingress push: both take effect. Push and pop same cycle: q_level unchanged.
//  Strict FIFO order; exactly one HAL op outstanding; rd_go and wr_go never high together.
//  Pointers wrap modulo DEPTH; q_level saturates at DEPTH by construction (push gated).
// TESTING
//  Empty idle bridge, slot 011 id=3 addr=0x123 -> rd_go next cycle, rd_addr=0x123<<28|mmio;
//   rd_done data=0xABC -> slot type 110 id=3 addr=0x123 data=0xABC at first empty slot.
//  Slot 001 id=7 data=0x55 with full=1 for 10 cycles -> wr_go held 11+ cycles, wr_data=0x55;
//   wr_done -> type 101 id=7 data=0 injected; err_timeout stays 0.
//  DEPTH=4: 6 back-to-back requests while HAL stalls -> 4 consumed, 2 slots untouched,
//   q_level=4; responses emerge in arrival order.
//  Resp pending, next slot holds consumable 011 -> one-cycle overwrite with response, request
//   queued (q_level+1).
//  TIMEOUT=16, rd_done withheld 20 cycles -> err_timeout high at cycle 16, op completes normally.
//  rst mid RD_WAIT -> rd_go low next cycle, q_level=0, no response packet ever injected.

Source files
------------

// File: rtl/ring_hal_bridge.sv
// Ring-stop endpoint: queues ring read/write requests, runs them one at a time on the HAL
// host-memory port and injects the write ack / read response back into the ring.
module ring_hal_bridge #(
  parameter int ADDR_W  = 36,
  parameter int DATA_W  = 512,
  parameter int ID_W    = 5,
  parameter int DEPTH   = 4,
  parameter int MMIO_W  = 28,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2:0]                ring_type_i,
  input  logic [ID_W-1:0]           ring_id_i,
  input  logic [ADDR_W-1:0]         ring_addr_i,
  input  logic [DATA_W-1:0]         ring_data_i,
  output logic                      ring_ovr_o,
  output logic [2:0]                ring_type_o,
  output logic [ID_W-1:0]           ring_id_o,
  output logic [ADDR_W-1:0]         ring_addr_o,
  output logic [DATA_W-1:0]         ring_data_o,
  input  logic [MMIO_W-1:0]         mmio_addr,
  output logic                      rd_go,
  output logic [63:0]               rd_addr,
  output logic                      wr_go,
  output logic [63:0]               wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  input  logic                      rd_done,
  input  logic [DATA_W-1:0]         rd_data,
  input  logic                      empty,
  input  logic                      wr_done,
  input  logic                      full,
  output logic [$clog2(DEPTH):0]    q_level,
  output logic                      err_timeout
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 2);

  localparam logic [2:0] T_EMPTY   = 3'b000;
  localparam logic [2:0] T_WR_REQ  = 3'b001;
  localparam logic [2:0] T_RD_REQ  = 3'b011;
  localparam logic [2:0] T_WR_ACK  = 3'b101;
  localparam logic [2:0] T_RD_RESP = 3'b110;

  typedef struct packed {
    logic              is_rd;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t            state, state_next;
  req_t              queue [DEPTH];
  req_t              incoming, head;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              slot_is_req, push, pop, inject;
  logic              wait_st, op_done;
  logic [63:0]       hal_addr;
  logic [TW-1:0]     timer;

  logic [2:0]        resp_type;
  logic [ID_W-1:0]   resp_id;
  logic [ADDR_W-1:0] resp_addr;
  logic [DATA_W-1:0] resp_data;

  // Ingress decode. An empty queue forwards the arriving request straight to the head so an
  // idle bridge issues the HAL op on the very next cycle.
  always_comb begin
    slot_is_req = (ring_type_i == T_WR_REQ) || (ring_type_i == T_RD_REQ);
    incoming    = '{is_rd: (ring_type_i == T_RD_REQ), id: ring_id_i,
                    addr: ring_addr_i, data: ring_data_i};
    push        = !rst && slot_is_req && (level != LW'(DEPTH));
    head        = (level == '0) ? incoming : queue[rd_ptr];
    hal_addr    = (64'(head.addr) << MMIO_W) | 64'(mmio_addr);
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    inject     = 1'b0;
    case (state)
      IDLE: begin
        if (level != '0 || push) begin
          pop        = 1'b1;
          state_next = head.is_rd ? RD_WAIT : WR_WAIT;
        end
      end
      RD_WAIT: if (rd_done) state_next = RESP;
      WR_WAIT: if (wr_done) state_next = RESP;
      RESP: begin
        // A consumed request slot is as good as an empty one: the response replaces it.
        if (!rst && (ring_type_i == T_EMPTY || push)) begin
          inject     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ring_ovr_o  = push || inject;
    ring_type_o = T_EMPTY;
    ring_id_o   = '0;
    ring_addr_o = '0;
    ring_data_o = '0;
    if (inject) begin
      ring_type_o = resp_type;
      ring_id_o   = resp_id;
      ring_addr_o = resp_addr;
      ring_data_o = resp_data;
    end
  end

  assign wait_st = (state == RD_WAIT) || (state == WR_WAIT);
  assign op_done = ((state == RD_WAIT) && rd_done) || ((state == WR_WAIT) && wr_done);
  assign q_level = level;

  // NOTE: the entry storage has no reset; level and the pointers alone say what is valid.
  always_ff @(posedge clk) begin
    if (push) queue[wr_ptr] <= incoming;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees
  // the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // HAL request side and response buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_go     <= 1'b0;
      wr_go     <= 1'b0;
      rd_addr   <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      resp_type <= T_EMPTY;
      resp_id   <= '0;
      resp_addr <= '0;
      resp_data <= '0;
    end else begin
      if (pop) begin
        resp_id   <= head.id;
        resp_addr <= head.addr;
        if (head.is_rd) begin
          rd_go   <= 1'b1;
          rd_addr <= hal_addr;
        end else begin
          wr_go   <= 1'b1;
          wr_addr <= hal_addr;
          wr_data <= head.data;
        end
      end
      if (state == RD_WAIT && rd_done) begin
        rd_go     <= 1'b0;
        resp_type <= T_RD_RESP;
        resp_data <= rd_data;
      end
      if (state == WR_WAIT && wr_done) begin
        wr_go     <= 1'b0;
        resp_type <= T_WR_ACK;
        resp_data <= '0;
      end
    end
  end

  // Wait-cycle timer: saturates at TIMEOUT and flags a sticky error without aborting the op.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer       <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (!wait_st || op_done)          timer <= '0;
      else if (timer != TW'(TIMEOUT))   timer <= timer + TW'(1);
      if (TIMEOUT != 0 && wait_st && !op_done && timer == TW'(TIMEOUT - 1))
        err_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ring_hal_bridge.sv
// Scoreboard bench for ring_hal_bridge: directed scenarios plus randomized ring traffic, with
// a memory-level reference model and a responsive HAL model.
module tb_ring_hal_bridge;

  localparam int ADDR_W  = 36;
  localparam int DATA_W  = 512;
  localparam int ID_W    = 5;
  localparam int DEPTH   = 4;
  localparam int MMIO_W  = 28;
  localparam int TIMEOUT = 16;
  localparam int LW      = $clog2(DEPTH) + 1;

  typedef logic [3+ID_W+ADDR_W+DATA_W-1:0] resp_t;
  typedef struct packed {
    logic              is_rd;
    logic [63:0]       addr;
    logic [DATA_W-1:0] data;
  } hal_op_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [2:0]        ring_type_i = '0;
  logic [ID_W-1:0]   ring_id_i = '0;
  logic [ADDR_W-1:0] ring_addr_i = '0;
  logic [DATA_W-1:0] ring_data_i = '0;
  logic              ring_ovr_o;
  logic [2:0]        ring_type_o;
  logic [ID_W-1:0]   ring_id_o;
  logic [ADDR_W-1:0] ring_addr_o;
  logic [DATA_W-1:0] ring_data_o;
  logic [MMIO_W-1:0] mmio_addr = 28'h5A3C0F1;
  logic              rd_go, wr_go;
  logic [63:0]       rd_addr, wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_done = 1'b0;
  logic [DATA_W-1:0] rd_data = '0;
  logic              empty = 1'b0;
  logic              wr_done = 1'b0;
  logic              full = 1'b0;
  logic [LW-1:0]     q_level;
  logic              err_timeout;

  always #5 clk = ~clk;

  ring_hal_bridge #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH),
    .MMIO_W(MMIO_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .ring_type_i(ring_type_i), .ring_id_i(ring_id_i), .ring_addr_i(ring_addr_i),
    .ring_data_i(ring_data_i), .ring_ovr_o(ring_ovr_o), .ring_type_o(ring_type_o),
    .ring_id_o(ring_id_o), .ring_addr_o(ring_addr_o), .ring_data_o(ring_data_o),
    .mmio_addr(mmio_addr), .rd_go(rd_go), .rd_addr(rd_addr), .wr_go(wr_go),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_done(rd_done), .rd_data(rd_data),
    .empty(empty), .wr_done(wr_done), .full(full), .q_level(q_level),
    .err_timeout(err_timeout)
  );

  resp_t             sb[$];
  hal_op_t           hal_q[$];
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] hal_mem [logic [63:0]];
  logic [ADDR_W-1:0] pool [8];
  logic              exp_consume = 1'b0;
  int                hal_max_delay = 0;
  int                checks = 0;
  int                errors = 0;
  int                resp_seen = 0;

  task automatic check(input string name, input logic [1023:0] got, input logic [1023:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Power-on contents of host memory, as a function of the ring address.
  function automatic logic [DATA_W-1:0] init_data(input logic [ADDR_W-1:0] a);
    logic [31:0] w;
    w = (32'(a) * 32'h9E3779B1) ^ 32'(a >> 32);
    return {(DATA_W/32){w}};
  endfunction

  function automatic logic [63:0] hal_addr_of(input logic [ADDR_W-1:0] a);
    return (64'(a) << MMIO_W) | 64'(mmio_addr);
  endfunction

  function automatic logic [DATA_W-1:0] rand_data();
    logic [DATA_W-1:0] d;
    for (int i = 0; i < DATA_W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Present one ring slot; an accepted request updates the reference model immediately,
  // which is valid because the bridge serves requests strictly in arrival order.
  task automatic drive_slot(input logic [2:0] t, input logic [ID_W-1:0] id,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic consume);
    logic [DATA_W-1:0] rv;
    @(posedge clk); #1;
    ring_type_i = t;
    ring_id_i   = id;
    ring_addr_i = a;
    ring_data_i = d;
    exp_consume = consume;
    if (consume) begin
      if (t == 3'b011) begin
        rv = ref_mem.exists(a) ? ref_mem[a] : init_data(a);
        sb.push_back({3'b110, id, a, rv});
        hal_q.push_back('{is_rd: 1'b1, addr: hal_addr_of(a), data: '0});
      end else begin
        ref_mem[a] = d;
        sb.push_back({3'b101, id, a, {DATA_W{1'b0}}});
        hal_q.push_back('{is_rd: 1'b0, addr: hal_addr_of(a), data: d});
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive_slot(3'b000, '0, '0, '0, 1'b0);
  endtask

  task automatic foreign(input int n);
    logic [2:0] kinds [5];
    kinds = '{3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
    repeat (n) drive_slot(kinds[$urandom_range(0, 4)], ID_W'($urandom), ADDR_W'($urandom),
                          rand_data(), 1'b0);
  endtask

  task automatic rand_req(input logic consume);
    logic [2:0] t;
    t = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b011;
    drive_slot(t, ID_W'($urandom), pool[$urandom_range(0, 7)], rand_data(), consume);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || hal_q.size() != 0) && n < 500) begin
      idle(1);
      n++;
    end
    check("drained", 32'(sb.size() + hal_q.size()), 0);
    idle(2);
  endtask

  // Ring monitor: sampled mid-cycle, away from the clock edge.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ring_type_i == 3'b001 || ring_type_i == 3'b011)
          check("consume", ring_ovr_o, exp_consume);
        else if (ring_type_i != 3'b000)
          check("foreign_untouched", ring_ovr_o, 0);
        if (ring_ovr_o && ring_type_o != 3'b000) begin
          resp_seen++;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got type %0h id %0h addr %0h, expected none",
                     ring_type_o, ring_id_o, ring_addr_o);
          end else begin
            e = sb.pop_front();
            check("resp_pkt", {ring_type_o, ring_id_o, ring_addr_o, ring_data_o}, e);
          end
        end
        if (rd_go || wr_go) check("go_exclusive", rd_go && wr_go, 0);
      end
    end
  end

  // HAL model: host memory that completes each op after a random delay unless stalled.
  initial begin
    hal_op_t cur;
    int      cnt = 0;
    int      delay = 0;
    logic    active = 1'b0;
    cur = '0;
    forever begin
      @(posedge clk); #1;
      rd_done = 1'b0;
      wr_done = 1'b0;
      if (!(rd_go || wr_go)) begin
        active = 1'b0;
      end else begin
        if (!active) begin
          active = 1'b1;
          cnt    = 0;
          delay  = $urandom_range(0, hal_max_delay);
          if (hal_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL hal_unexpected_op: rd_go %0b rd_addr %0h wr_go %0b wr_addr %0h",
                     rd_go, rd_addr, wr_go, wr_addr);
            cur = '{is_rd: rd_go, addr: (rd_go ? rd_addr : wr_addr), data: wr_data};
          end else begin
            cur = hal_q.pop_front();
            check("hal_kind", rd_go, cur.is_rd);
            check("hal_addr", rd_go ? rd_addr : wr_addr, cur.addr);
            if (!cur.is_rd) check("hal_wdata", wr_data, cur.data);
          end
        end
        if (rd_go && !empty && cnt >= delay) begin
          check("rd_addr_stable", rd_addr, cur.addr);
          rd_data = hal_mem.exists(rd_addr) ? hal_mem[rd_addr]
                                            : init_data(ADDR_W'(rd_addr >> MMIO_W));
          rd_done = 1'b1;
          active  = 1'b0;
        end else if (wr_go && !full && cnt >= delay) begin
          check("wr_stable", {wr_addr, wr_data}, {cur.addr, cur.data});
          hal_mem[wr_addr] = wr_data;
          wr_done = 1'b1;
          active  = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_go;
    int k;
    int seen0;
    for (int i = 0; i < 8; i++) pool[i] = {4'($urandom), 32'($urandom)};

    // Reset: a request offered while rst is high must be ignored.
    rst = 1'b1;
    idle(2);
    drive_slot(3'b011, 5'd1, 36'h777, '0, 1'b0);
    @(negedge clk);
    check("rst_ovr", ring_ovr_o, 0);
    check("rst_type_o", ring_type_o, 0);
    check("rst_rd_go", rd_go, 0);
    check("rst_wr_go", wr_go, 0);
    check("rst_q_level", q_level, 0);
    check("rst_err", err_timeout, 0);
    check("rst_rd_addr", rd_addr, 0);
    drive_slot(3'b000, '0, '0, '0, 1'b0);
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    check("post_rst_q_level", q_level, 0);
    check("post_rst_rd_go", rd_go, 0);

    // Single read on an idle bridge: go on the next cycle, response at first empty slot.
    ref_mem[36'h123] = 512'hABC;
    hal_mem[hal_addr_of(36'h123)] = 512'hABC;
    drive_slot(3'b011, 5'd3, 36'h123, '0, 1'b1);
    idle(1);
    @(negedge clk);
    check("rd_go_latency", rd_go, 1);
    check("rd_addr_format", rd_addr, (64'h123 << 28) | 64'(mmio_addr));
    drain();

    // Write held off by a full HAL for 10 cycles.
    full = 1'b1;
    drive_slot(3'b001, 5'd7, 36'h456, 512'h55, 1'b1);
    n_go = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      @(negedge clk);
      if (wr_go) n_go++;
      check("wr_data_held", wr_data, 512'h55);
    end
    full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      @(negedge clk);
      if (!wr_go) break;
      n_go++;
    end
    check("wr_go_cycles_ge_11", n_go >= 11, 1);
    drain();
    check("wr_no_timeout", err_timeout, 0);

    // Back-pressure: one op stalled in the HAL, then 6 requests -> 4 taken, 2 left alone.
    empty = 1'b1;
    drive_slot(3'b011, 5'd9, pool[0], '0, 1'b1);
    idle(2);
    for (int i = 0; i < 6; i++) rand_req(i < 4);
    idle(1);
    @(negedge clk);
    check("bp_q_level_full", q_level, DEPTH);
    empty = 1'b0;
    drain();

    // Response pending behind foreign slots, then injected over a consumable request.
    empty = 1'b1;
    drive_slot(3'b011, 5'd11, pool[1], '0, 1'b1);
    idle(2);
    empty = 1'b0;
    foreign(6);
    @(negedge clk);
    check("same_slot_q_before", q_level, 0);
    drive_slot(3'b011, 5'd12, pool[2], '0, 1'b1);
    @(negedge clk);
    check("same_slot_ovr", ring_ovr_o, 1);
    check("same_slot_type", ring_type_o, 3'b110);
    check("same_slot_id", ring_id_o, 5'd11);
    idle(1);
    @(negedge clk);
    check("same_slot_q_after", q_level, 1);
    drain();

    // Randomized traffic; outstanding requests kept below DEPTH so every one is taken.
    hal_max_delay = 6;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: idle(1);
        4, 5:       foreign(1);
        default: begin
          if (sb.size() < DEPTH) rand_req(1'b1);
          else                   idle(1);
        end
      endcase
    end
    drain();
    hal_max_delay = 0;
    check("random_no_timeout", err_timeout, 0);

    // HAL timeout: read withheld for 20 cycles, flag sticks, op still completes.
    empty = 1'b1;
    drive_slot(3'b011, 5'd20, pool[3], '0, 1'b1);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      idle(1);
      @(negedge clk);
      if (rd_go) k++;
      if (k == 12) check("timeout_not_early", err_timeout, 0);
    end
    check("timeout_wait_cycles", k, 20);
    check("timeout_set", err_timeout, 1);
    empty = 1'b0;
    drain();
    check("timeout_sticky", err_timeout, 1);

    // Reset in the middle of a read wait with two requests queued.
    empty = 1'b1;
    drive_slot(3'b011, 5'd21, pool[4], '0, 1'b1);
    drive_slot(3'b011, 5'd22, pool[5], '0, 1'b1);
    drive_slot(3'b011, 5'd23, pool[6], '0, 1'b1);
    idle(2);
    @(negedge clk);
    check("mid_rst_q_before", q_level, 2);
    check("mid_rst_rd_go_before", rd_go, 1);
    @(posedge clk); #1;
    rst         = 1'b1;
    ring_type_i = 3'b000;
    exp_consume = 1'b0;
    sb.delete();
    hal_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rd_go", rd_go, 0);
    check("mid_rst_q_level", q_level, 0);
    check("mid_rst_err_cleared", err_timeout, 0);
    seen0 = resp_seen;
    empty = 1'b0;
    idle(30);
    check("mid_rst_no_resp", resp_seen - seen0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
